// File: rtl/tile_flip_pkg.sv
`default_nettype none
// tile_flip_pkg -- shared state encoding and board geometry for the memory-game sequencer. Rev 1.0
package tile_flip_pkg;

  localparam int NUM_TILES = 16;
  localparam int TILE_W    = 3;
  localparam int NUM_PAIRS = 8;
  localparam int IDX_W     = 4;
  localparam int BOARD_W   = NUM_TILES * TILE_W;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_FIRST  = 3'd1,
    ST_WAIT_SECOND = 3'd2,
    ST_COMPARE     = 3'd3,
    ST_REVEAL      = 3'd4,
    ST_DONE        = 3'd5
  } state_e;

  function automatic logic [TILE_W-1:0] tile_value(input logic [BOARD_W-1:0] board,
                                                   input logic [IDX_W-1:0]   idx);
    return board[int'(idx) * TILE_W +: TILE_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_flip_controller_reveal_timer.sv
`default_nettype none
// reveal_timer -- loadable down-counter; done marks the final cycle of the load window. Rev 1.0
module reveal_timer #(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int                 CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(CYCLES);
  localparam logic [CNT_W-1:0]   LAST_VAL = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // Loaded with CYCLES, so the counter reads 1 on the last of CYCLES busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= LOAD_VAL;
    end else if (busy) begin
      count_q <= count_q - LAST_VAL;
    end
  end

  assign busy = (count_q != '0);
  assign done = (count_q == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/tile_flip_controller.sv
`default_nettype none
// tile_flip_controller -- memory-board game sequencer: board snapshot, pair compare, timed reveal. Rev 1.0
module tile_flip_controller
  import tile_flip_pkg::*;
#(
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] shuffled_vals,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  output logic        sel_ready,
  output logic [47:0] tile_vals,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        match_pulse,
  output logic        miss_pulse,
  output logic        game_over
);

  state_e                 state_q;
  logic [BOARD_W-1:0]     tile_vals_q;
  logic [NUM_TILES-1:0]   matched_q;
  logic [NUM_TILES-1:0]   open_q;
  logic [IDX_W-1:0]       first_q;
  logic [IDX_W-1:0]       second_q;
  logic [3:0]             pairs_q;
  logic [7:0]             moves_q;
  logic                   match_pulse_q;
  logic                   miss_pulse_q;

  logic                   accept_d;
  logic                   values_equal_d;
  logic [NUM_TILES-1:0]   pair_mask_d;
  logic                   timer_load_d;
  logic                   timer_busy;
  logic                   timer_done;

  assign sel_ready      = (state_q == ST_WAIT_FIRST) || (state_q == ST_WAIT_SECOND);
  assign face_up        = matched_q | open_q;
  assign accept_d       = sel_valid && sel_ready && !face_up[sel_idx];
  assign values_equal_d = (tile_value(tile_vals_q, first_q) == tile_value(tile_vals_q, second_q));
  assign pair_mask_d    = (16'd1 << first_q) | (16'd1 << second_q);
  assign timer_load_d   = (state_q == ST_COMPARE) && !values_equal_d;

  reveal_timer #(
    .CYCLES (REVEAL_CYCLES)
  ) u_reveal_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_d),
    .busy  (timer_busy),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tile_vals_q   <= '0;
      matched_q     <= '0;
      open_q        <= '0;
      first_q       <= '0;
      second_q      <= '0;
      pairs_q       <= '0;
      moves_q       <= '0;
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
    end else begin
      match_pulse_q <= 1'b0;
      miss_pulse_q  <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            tile_vals_q <= shuffled_vals;
            matched_q   <= '0;
            open_q      <= '0;
            pairs_q     <= '0;
            moves_q     <= '0;
            state_q     <= ST_WAIT_FIRST;
          end
        end
        ST_WAIT_FIRST: begin
          if (accept_d) begin
            open_q[sel_idx] <= 1'b1;
            first_q         <= sel_idx;
            state_q         <= ST_WAIT_SECOND;
          end
        end
        ST_WAIT_SECOND: begin
          if (accept_d) begin
            open_q[sel_idx] <= 1'b1;
            second_q        <= sel_idx;
            state_q         <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (moves_q != 8'hFF) begin
            moves_q <= moves_q + 8'd1;
          end
          if (values_equal_d) begin
            matched_q     <= matched_q | pair_mask_d;
            open_q        <= open_q & ~pair_mask_d;
            pairs_q       <= pairs_q + 4'd1;
            match_pulse_q <= 1'b1;
            state_q       <= (pairs_q + 4'd1 == 4'(NUM_PAIRS)) ? ST_DONE : ST_WAIT_FIRST;
          end else begin
            miss_pulse_q <= 1'b1;
            state_q      <= ST_REVEAL;
          end
        end
        ST_REVEAL: begin
          // An idle timer here can only mean a lost load; fall back rather than stall.
          if (timer_done || !timer_busy) begin
            open_q  <= open_q & ~pair_mask_d;
            state_q <= ST_WAIT_FIRST;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tile_vals   = tile_vals_q;
  assign matched     = matched_q;
  assign pairs_found = pairs_q;
  assign moves       = moves_q;
  assign match_pulse = match_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign game_over   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tile_flip_controller.sv
`default_nettype none
// tb_tile_flip_controller -- directed game scenarios checked against a behavioural board model.
module tb_tile_flip_controller;

  localparam int          RC      = 4;
  localparam logic [47:0] BOARD_A = 48'o7654321076543210;
  localparam logic [47:0] BOARD_B = 48'h123456789ABC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [47:0] shuffled_vals = '0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_idx = '0;
  logic        sel_ready;
  logic [47:0] tile_vals;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        match_pulse;
  logic        miss_pulse;
  logic        game_over;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tile_flip_controller #(
    .REVEAL_CYCLES (RC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .shuffled_vals (shuffled_vals),
    .sel_valid     (sel_valid),
    .sel_idx       (sel_idx),
    .sel_ready     (sel_ready),
    .tile_vals     (tile_vals),
    .face_up       (face_up),
    .matched       (matched),
    .pairs_found   (pairs_found),
    .moves         (moves),
    .match_pulse   (match_pulse),
    .miss_pulse    (miss_pulse),
    .game_over     (game_over)
  );

  // Board model: the open pair is a list of tile indices, a reveal is a countdown.
  logic [2:0]  m_board [16];
  logic [47:0] m_tile_vals = '0;
  logic [15:0] m_matched = '0;
  int          m_open[$];
  int          m_pairs = 0;
  int          m_moves = 0;
  int          m_show = 0;
  bit          m_playing = 1'b0;
  bit          m_over = 1'b0;
  bit          m_judging = 1'b0;
  bit          m_match = 1'b0;
  bit          m_miss = 1'b0;

  function automatic logic [15:0] m_face();
    logic [15:0] f;
    f = m_matched;
    foreach (m_open[k]) f[m_open[k]] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [15:0] fu;
    if (reset) begin
      m_tile_vals = '0; m_matched = '0; m_open.delete();
      m_pairs = 0; m_moves = 0; m_show = 0;
      m_playing = 1'b0; m_over = 1'b0; m_judging = 1'b0; m_match = 1'b0; m_miss = 1'b0;
    end else begin
      m_match = 1'b0;
      m_miss  = 1'b0;
      fu = m_face();
      if ((!m_playing || m_over) && start) begin
        m_tile_vals = shuffled_vals;
        for (int i = 0; i < 16; i++) m_board[i] = shuffled_vals[3*i +: 3];
        m_matched = '0; m_open.delete(); m_pairs = 0; m_moves = 0; m_show = 0;
        m_playing = 1'b1; m_over = 1'b0; m_judging = 1'b0;
      end else if (m_playing && !m_over) begin
        if (m_judging) begin
          m_judging = 1'b0;
          if (m_moves < 255) m_moves++;
          if (m_board[m_open[0]] == m_board[m_open[1]]) begin
            m_matched[m_open[0]] = 1'b1;
            m_matched[m_open[1]] = 1'b1;
            m_open.delete();
            m_pairs++;
            m_match = 1'b1;
            if (m_pairs == 8) m_over = 1'b1;
          end else begin
            m_miss = 1'b1;
            m_show = RC;
          end
        end else if (m_show > 0) begin
          m_show--;
          if (m_show == 0) m_open.delete();
        end else if (sel_valid && !fu[sel_idx]) begin
          m_open.push_back(int'(sel_idx));
          if (m_open.size() == 2) m_judging = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("tile_vals",   tile_vals,   m_tile_vals);
    chk("face_up",     face_up,     m_face());
    chk("matched",     matched,     m_matched);
    chk("pairs_found", pairs_found, 64'(m_pairs));
    chk("moves",       moves,       64'(m_moves));
    chk("match_pulse", match_pulse, m_match);
    chk("miss_pulse",  miss_pulse,  m_miss);
    chk("game_over",   game_over,   m_over);
    chk("sel_ready",   sel_ready,   m_playing && !m_over && !m_judging && (m_show == 0));
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic select(input logic [3:0] idx);
    @(posedge clk); #2;
    sel_valid = 1'b1;
    sel_idx   = idx;
    @(posedge clk); #2;
    sel_valid = 1'b0;
  endtask

  task automatic do_start(input logic [47:0] b, input bit with_sel, input logic [3:0] idx);
    @(posedge clk); #2;
    shuffled_vals = b;
    start         = 1'b1;
    sel_valid     = with_sel;
    sel_idx       = idx;
    @(posedge clk); #2;
    start         = 1'b0;
    sel_valid     = 1'b0;
    shuffled_vals = ~b;
  endtask

  int cnt;

  initial begin
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tile_vals", tile_vals, 48'h0);
    chk("rst_face_up",   face_up,   16'h0);
    chk("rst_sel_ready", sel_ready, 1'b0);
    chk("rst_moves",     moves,     8'd0);

    do_start(BOARD_A, 1'b0, 4'd0);
    @(negedge clk);
    chk("start_tile_vals", tile_vals,   BOARD_A);
    chk("start_sel_ready", sel_ready,   1'b1);
    chk("start_pairs",     pairs_found, 4'd0);

    select(4'd0); select(4'd8);
    @(posedge clk); @(negedge clk);
    chk("match_pulse_hi", match_pulse, 1'b1);
    chk("match_matched",  matched,     16'h0101);
    chk("match_pairs",    pairs_found, 4'd1);
    chk("match_moves",    moves,       8'd1);
    chk("match_ready",    sel_ready,   1'b1);
    @(negedge clk);
    chk("match_pulse_lo", match_pulse, 1'b0);

    select(4'd1); select(4'd2);
    @(posedge clk); @(negedge clk);
    chk("miss_pulse_hi", miss_pulse, 1'b1);
    chk("miss_face_up",  face_up,    16'h0107);
    chk("miss_moves",    moves,      8'd2);
    #1;
    sel_valid = 1'b1;
    sel_idx   = 4'd5;
    cnt = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) sel_valid = 1'b0;
      if (face_up[1] && face_up[2]) cnt++;
      else break;
    end
    chk("reveal_len",     cnt,       RC);
    chk("reveal_face_dn", face_up,   16'h0101);
    chk("reveal_ready",   sel_ready, 1'b1);

    select(4'd1); select(4'd1); select(4'd0);
    @(negedge clk);
    chk("illegal_moves",   moves,     8'd2);
    chk("illegal_face_up", face_up,   16'h0103);
    chk("illegal_ready",   sel_ready, 1'b1);
    select(4'd9);
    @(posedge clk); @(negedge clk);
    chk("pair19_matched", matched, 16'h0303);
    chk("pair19_moves",   moves,   8'd3);

    for (int i = 2; i < 8; i++) begin
      select(4'(i)); select(4'(i + 8));
      @(posedge clk);
    end
    @(negedge clk);
    chk("full_game_over", game_over,   1'b1);
    chk("full_pairs",     pairs_found, 4'd8);
    chk("full_moves",     moves,       8'd9);
    chk("full_ready",     sel_ready,   1'b0);
    select(4'd3);
    @(negedge clk);
    chk("done_moves", moves, 8'd9);

    do_start(BOARD_B, 1'b1, 4'd3);
    @(negedge clk);
    chk("restart_tile_vals", tile_vals, BOARD_B);
    chk("restart_matched",   matched,   16'h0);
    chk("restart_face_up",   face_up,   16'h0);
    chk("restart_moves",     moves,     8'd0);
    chk("restart_game_over", game_over, 1'b0);

    select(4'd0); select(4'd1);
    @(posedge clk); @(negedge clk);
    chk("b_miss_pulse", miss_pulse, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_face_up",   face_up,   16'h0);
    chk("arst_tile_vals", tile_vals, 48'h0);
    chk("arst_moves",     moves,     8'd0);
    chk("arst_sel_ready", sel_ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", sel_ready, 1'b0);
    do_start(BOARD_A, 1'b0, 4'd0);
    @(negedge clk);
    chk("post_rst_start_ready", sel_ready, 1'b1);
    select(4'd3); select(4'd4);
    repeat (RC + 3) @(negedge clk);
    chk("post_rst_reveal_done", face_up, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
